// File: rtl/i4_vector_sequencer_if.sv
// Bundle between the i4 vector sequencer, its chunk source, the i4 core and the response sink.
// VEC_TOGGLE_COUNT_EN adds the toggle_cnt signal.
interface i4_vector_sequencer_if #(
    parameter int IN_W    = 192,
    parameter int OUT_W   = 6,
    parameter int CHUNK_W = 16
);
    // Valid/ready: a transfer happens on a rising edge where valid && ready. The sender
    // holds data stable while valid is high and unaccepted; ready may depend on state only.
    logic               in_valid;
    logic               in_ready;
    logic [CHUNK_W-1:0] in_data;
    logic [7:0]         settle_cfg;
    logic [IN_W-1:0]    pi_vec;
    logic [OUT_W-1:0]   po_vec;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [OUT_W-1:0]   rsp_data;
    logic               busy;
    logic [1:0]         state_dbg;
`ifdef VEC_TOGGLE_COUNT_EN
    logic [7:0]         toggle_cnt;
`endif

    modport master (
        output in_valid, in_data, settle_cfg, po_vec, rsp_ready,
        input  in_ready, pi_vec, rsp_valid, rsp_data, busy, state_dbg
`ifdef VEC_TOGGLE_COUNT_EN
        , input toggle_cnt
`endif
    );

    modport slave (
        input  in_valid, in_data, settle_cfg, po_vec, rsp_ready,
        output in_ready, pi_vec, rsp_valid, rsp_data, busy, state_dbg
`ifdef VEC_TOGGLE_COUNT_EN
        , output toggle_cnt
`endif
    );
endinterface

// File: rtl/i4_vector_sequencer.sv
// Loads a wide stimulus vector in chunks, applies it to the i4 core in one edge, settles,
// captures po and returns it. Optional macro VEC_TOGGLE_COUNT_EN adds a toggle counter.
module i4_vector_sequencer #(
    parameter int IN_W       = 192,
    parameter int OUT_W      = 6,
    parameter int CHUNK_W    = 16,
    parameter int SETTLE_CYC = 2
) (
    input logic clk,
    input logic rst,
    i4_vector_sequencer_if.slave bus
);
    localparam int NCHUNK = IN_W / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {LOAD = 2'd0, APPLY = 2'd1, SETTLE = 2'd2, RESP = 2'd3} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic               full;
    logic [IN_W-1:0]    shadow;
    logic [IN_W-1:0]    pi_q;
    logic [7:0]         settle_cnt;
    logic [OUT_W-1:0]   rsp_q;
    logic               rsp_v;
    logic               in_ready_c;
    logic               xfer;
    logic               last_xfer;
    logic               rsp_hs;
    logic [7:0]         settle_eff;

    always_comb begin
        in_ready_c = 1'b0;
        state_next = state;
        // While a response is pending the shadow can take one full vector, then stalls.
        in_ready_c = (state == LOAD) || ((state == RESP) && !full);
        xfer       = bus.in_valid && in_ready_c;
        last_xfer  = xfer && (idx == LAST_IDX);
        rsp_hs     = rsp_v && bus.rsp_ready;
        settle_eff = (bus.settle_cfg != 8'd0) ? bus.settle_cfg : 8'(SETTLE_CYC);
        case (state)
            LOAD:    if (last_xfer) state_next = APPLY;
            APPLY:   state_next = SETTLE;
            SETTLE:  if (settle_cnt <= 8'd1) state_next = RESP;
            RESP:    if (rsp_hs) state_next = (full || last_xfer) ? APPLY : LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            idx        <= '0;
            full       <= 1'b0;
            shadow     <= '0;
            pi_q       <= '0;
            settle_cnt <= 8'd0;
            rsp_q      <= '0;
            rsp_v      <= 1'b0;
        end else begin
            state <= state_next;
            if (xfer) begin
                shadow[idx*CHUNK_W +: CHUNK_W] <= bus.in_data;
                idx <= last_xfer ? '0 : idx + 1'b1;
            end
            if ((state == RESP) && last_xfer && !rsp_hs) full <= 1'b1;
            case (state)
                APPLY: begin
                    pi_q       <= shadow;
                    settle_cnt <= settle_eff;
                    full       <= 1'b0;
                end
                SETTLE: begin
                    if (settle_cnt <= 8'd1) begin
                        rsp_q <= bus.po_vec;
                        rsp_v <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                RESP: if (rsp_hs) rsp_v <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef VEC_TOGGLE_COUNT_EN
    logic [7:0] toggle_q;
    logic [7:0] pop_c;

    // Hamming distance between the vector about to be applied and the one on the core now.
    always_comb begin
        pop_c = 8'd0;
        for (int k = 0; k < IN_W; k++) pop_c = pop_c + 8'(shadow[k] ^ pi_q[k]);
    end

    always_ff @(posedge clk) begin
        if (rst)                 toggle_q <= 8'd0;
        else if (state == APPLY) toggle_q <= pop_c;
    end

    assign bus.toggle_cnt = toggle_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.pi_vec    = pi_q;
    assign bus.rsp_valid = rsp_v;
    assign bus.rsp_data  = rsp_q;
    assign bus.busy      = !((state == LOAD) && (idx == '0));
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_i4_vector_sequencer.sv
// Directed bench for i4_vector_sequencer: drivers push expected responses, a monitor
// checks them at each response handshake; latency and flow-control points checked inline.
module tb_i4_vector_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [5:0]   exp_q[$];
    logic [191:0] exp_pi_q[$];

    i4_vector_sequencer_if bus ();

    i4_vector_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] rep(input logic [15:0] c);
        return {12{c}};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [5:0] rsp, input logic [191:0] pi);
        exp_q.push_back(rsp);
        exp_pi_q.push_back(pi);
    endtask

    task automatic send_chunk(input logic [15:0] d, input bit gap);
        int   guard;
        logic acc;
        if (gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 16'hDEAD;
            wait_cycles(1);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        guard = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL chunk_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic send_vec(input logic [15:0] c, input bit gap, input int n);
        for (int i = 0; i < n; i++) send_chunk(c, gap);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            wait_cycles(1);
            g++;
        end
        chk("drain_pending", 192'(exp_q.size()), 192'd0);
    endtask

    // Monitor: each accepted response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%0h required=none", bus.rsp_data);
            end else begin
                chk("rsp_data", 192'(bus.rsp_data), 192'(exp_q.pop_front()));
                chk("rsp_pi_vec", bus.pi_vec, exp_pi_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = 16'h0;
        bus.settle_cfg = 8'd0;
        bus.po_vec     = 6'h00;
        bus.rsp_ready  = 1'b0;
        wait_cycles(2);
        rst = 1'b0;
        chk("rst_in_ready", 192'(bus.in_ready), 192'd1);
        chk("rst_busy", 192'(bus.busy), 192'd0);
        chk("rst_rsp_valid", 192'(bus.rsp_valid), 192'd0);
        chk("rst_rsp_data", 192'(bus.rsp_data), 192'd0);
        chk("rst_pi_vec", bus.pi_vec, 192'd0);
        chk("rst_state", 192'(bus.state_dbg), 192'd0);
`ifdef VEC_TOGGLE_COUNT_EN
        chk("rst_toggle", 192'(bus.toggle_cnt), 192'd0);
`endif

        // Test 1: all ones, default settle of 2, po tied to 3C.
        bus.po_vec = 6'h3C;
        push_exp(6'h3C, {192{1'b1}});
        send_vec(16'hFFFF, 1'b0, 12);
        chk("t1_state_apply", 192'(bus.state_dbg), 192'd1);
        chk("t1_pi_before", bus.pi_vec, 192'd0);
        chk("t1_busy", 192'(bus.busy), 192'd1);
        wait_cycles(1);
        chk("t1_pi_applied", bus.pi_vec, {192{1'b1}});
        chk("t1_rsp_early1", 192'(bus.rsp_valid), 192'd0);
`ifdef VEC_TOGGLE_COUNT_EN
        chk("t1_toggle", 192'(bus.toggle_cnt), 192'd192);
`endif
        wait_cycles(1);
        chk("t1_rsp_early2", 192'(bus.rsp_valid), 192'd0);
        wait_cycles(1);
        chk("t1_rsp_valid", 192'(bus.rsp_valid), 192'd1);
        chk("t1_busy_resp", 192'(bus.busy), 192'd1);
        bus.rsp_ready = 1'b1;
        wait_cycles(1);
        bus.rsp_ready = 1'b0;
        chk("t1_rsp_cleared", 192'(bus.rsp_valid), 192'd0);
        chk("t1_busy_idle", 192'(bus.busy), 192'd0);

        // Test 2: settle override 5, po changes three cycles after apply.
        bus.po_vec     = 6'h00;
        bus.settle_cfg = 8'd5;
        push_exp(6'h21, 192'h1);
        send_chunk(16'h0001, 1'b0);
        send_vec(16'h0000, 1'b0, 11);
        wait_cycles(1);
        chk("t2_pi_applied", bus.pi_vec, 192'h1);
        bus.settle_cfg = 8'd0;
        wait_cycles(3);
        bus.po_vec = 6'h21;
        wait_cycles(1);
        chk("t2_rsp_early", 192'(bus.rsp_valid), 192'd0);
        wait_cycles(1);
        chk("t2_rsp_valid", 192'(bus.rsp_valid), 192'd1);

        // Test 3: stream a full vector while the response is held.
        send_vec(16'hA5A5, 1'b0, 12);
        chk("t3_in_ready_low", 192'(bus.in_ready), 192'd0);
        chk("t3_pi_held", bus.pi_vec, 192'h1);
        chk("t3_state_resp", 192'(bus.state_dbg), 192'd3);
        wait_cycles(2);
        chk("t3_in_ready_still_low", 192'(bus.in_ready), 192'd0);
        chk("t3_rsp_still_valid", 192'(bus.rsp_valid), 192'd1);
        push_exp(6'h15, rep(16'hA5A5));
        bus.po_vec    = 6'h15;
        bus.rsp_ready = 1'b1;
        wait_cycles(1);
        chk("t3_state_apply", 192'(bus.state_dbg), 192'd1);
        chk("t3_pi_not_yet", bus.pi_vec, 192'h1);
        wait_cycles(1);
        chk("t3_pi_applied", bus.pi_vec, rep(16'hA5A5));
        wait_drain();

        // Test 4: reset in the middle of a load discards the partial shadow.
        send_vec(16'hFFFF, 1'b0, 7);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        chk("t4_pi_zero", bus.pi_vec, 192'd0);
        chk("t4_busy", 192'(bus.busy), 192'd0);
        chk("t4_in_ready", 192'(bus.in_ready), 192'd1);
        chk("t4_rsp_data", 192'(bus.rsp_data), 192'd0);
        bus.po_vec = 6'h2A;
        push_exp(6'h2A, rep(16'h1234));
        send_vec(16'h1234, 1'b0, 12);
        wait_drain();

        // Test 5: in_valid toggling with garbage data in the idle cycles.
        bus.po_vec = 6'h07;
        push_exp(6'h07, rep(16'h0F0F));
        send_vec(16'h0F0F, 1'b1, 11);
        chk("t5_state_load", 192'(bus.state_dbg), 192'd0);
        chk("t5_busy", 192'(bus.busy), 192'd1);
        send_chunk(16'h0F0F, 1'b1);
        chk("t5_state_apply", 192'(bus.state_dbg), 192'd1);
        wait_drain();

        // Test 6: all ones from reset, then 0x5555 repeated.
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        bus.po_vec = 6'h3F;
        push_exp(6'h3F, {192{1'b1}});
        send_vec(16'hFFFF, 1'b0, 12);
        wait_cycles(1);
`ifdef VEC_TOGGLE_COUNT_EN
        chk("t6_toggle_192", 192'(bus.toggle_cnt), 192'd192);
`endif
        wait_drain();
        bus.po_vec = 6'h11;
        push_exp(6'h11, rep(16'h5555));
        send_vec(16'h5555, 1'b0, 12);
        wait_cycles(1);
        chk("t6_pi_5555", bus.pi_vec, rep(16'h5555));
`ifdef VEC_TOGGLE_COUNT_EN
        chk("t6_toggle_96", 192'(bus.toggle_cnt), 192'd96);
`endif
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i4_vector_sequencer.md
Name: i4_vector_sequencer

Overview:
- Upstream stimulus stage for the i4 combinational core in the nanosim power-simulation flow.
- Assembles a 192-bit input vector from 16-bit chunks into a shadow register.
- Applies the whole vector to the core's pi inputs in a single clock edge, so all toggles land in one power-trace cycle.
- Waits a programmable settle time, then captures the 6-bit po response and returns it over a valid/ready handshake.

Parameters:
- IN_W, 192, width of applied vector (pi000..pi191; bit k drives pi k)
- OUT_W, 6, width of captured response (po0..po5; bit k from po k)
- CHUNK_W, 16, load chunk width; IN_W must be a multiple of CHUNK_W
- SETTLE_CYC, 2, default settle cycles between apply and capture; must be ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  chunk valid
- in_ready  out  1  sequencer accepts chunk
- in_data  in  CHUNK_W  chunk; first chunk = bits [CHUNK_W-1:0], ascending
- settle_cfg  in  8  settle override; 0 = use SETTLE_CYC; sampled at apply
- pi_vec  out  IN_W  registered vector driven to core inputs
- po_vec  in  OUT_W  core outputs (combinational from pi_vec)
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  response consumed
- rsp_data  out  OUT_W  captured po_vec
- busy  out  1  high in every state except LOAD with chunk count 0

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset, when rst is high at a rising edge:
  - state=LOAD, chunk count=0, shadow=0, pi_vec=0
  - rsp_valid=0, rsp_data=0, in_ready=1 (from the following cycle), busy=0
  - rst overrides everything in that cycle, including a mid-load, mid-settle or pending response; the partial shadow is discarded.
- LOAD:
  - in_ready=1. A chunk transfers when in_valid&&in_ready.
  - The chunk is written into shadow[idx*CHUNK_W +: CHUNK_W] and idx increments.
  - On the transfer with idx==IN_W/CHUNK_W-1 (11 at default): idx wraps to 0 and the next state is APPLY.
  - in_valid without a transfer has no effect. in_data is ignored when in_valid=0.
- APPLY (1 cycle):
  - pi_vec<=shadow, all bits on the same edge.
  - Settle counter loaded with (settle_cfg!=0 ? settle_cfg : SETTLE_CYC).
  - in_ready=0. Next state SETTLE.
- SETTLE:
  - Counter decrements each cycle; in_ready=0.
  - When counter==1: rsp_data<=po_vec, rsp_valid<=1, next state RESP.
  - The capture therefore occurs N cycles after the pi_vec update edge (N = effective settle value).
- RESP:
  - rsp_valid=1; rsp_data and pi_vec are stable.
  - in_ready=1: the next vector may load into the shadow concurrently, and pi_vec does not change during this.
  - On rsp_valid&&rsp_ready: rsp_valid<=0. Next state is APPLY if the final chunk transfers in the same cycle or has already been loaded; otherwise LOAD, keeping the current idx.
  - If the final chunk arrives while the response is still pending: in_ready drops to 0 until the handshake completes, then APPLY follows.
- Latency:
  - Last chunk transfer at edge T → pi_vec updates at T+1 → rsp_valid rises at T+1+N.
- Arithmetic:
  - idx is ceil(log2(IN_W/CHUNK_W)) bits wide.
  - The settle counter is 8 bits and never underflows.
- pi_vec holds its last applied value indefinitely. It never shows a partially loaded vector.

Optional Feature:
- Macro: VEC_TOGGLE_COUNT_EN.
- Defined:
  - Adds output port toggle_cnt, 8 bits.
  - At APPLY, it registers popcount(shadow ^ pi_vec), i.e. the Hamming distance between the old and new applied vector (range 0..192). This is a power-model proxy.
  - It updates on the same edge as pi_vec, resets to 0, and holds until the next APPLY.
- Undefined:
  - The port is absent and no popcount logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset, then load 12 chunks 16'hFFFF → pi_vec=all ones one cycle after the 12th transfer; with po_vec tied to 6'h3C and settle_cfg=0: rsp_valid rises 2 cycles later, rsp_data=6'h3C, busy=1 until accepted.
- settle_cfg=5, chunks 0x0001,0,...,0 → pi_vec=192'h1; po_vec changes from 6'h00 to 6'h21 at cycle 3 after apply; capture at cycle 5 gives rsp_data=6'h21.
- Hold rsp_ready=0 and stream a full second vector (chunks 0xA5A5) → in_ready=0 after the 12th chunk, pi_vec unchanged; raise rsp_ready → APPLY on the next edge, pi_vec=0xA5A5 repeated.
- Assert rst after 7 of 12 chunks → pi_vec stays 0, idx=0; 12 fresh chunks 0x1234 apply exactly 0x1234 repeated, with no stale data.
- in_valid toggled 1/0 every cycle across a load → exactly 12 transfers; the apply edge occurs on the 12th accepted chunk.
- VEC_TOGGLE_COUNT_EN: apply all-ones then 0x5555 repeated → toggle_cnt=192, then 96.
